// File: rtl/gc_pkg.sv
// Shared GameCube link definitions: sequencer states, command bytes and capture widths.
package gc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIdTx,
        StIdWait,
        StPollTx,
        StPollWait,
        StPollGap
    } gc_seq_state_t;

    localparam logic [7:0]  GC_ID_CMD      = 8'h00;
    localparam logic [23:0] GC_POLL_CMD    = 24'h400300;
    localparam int unsigned GC_ID_BITS     = 24;
    localparam int unsigned GC_BUTTON_BITS = 64;

endpackage

// File: rtl/gc_poll_sequencer_if.sv
// Sequencer-side bundle: transmitter handshake, receiver control and link status.
interface gc_poll_sequencer_if;
    logic        enable;
    logic        init_req;
    logic [23:0] tx_cmd;
    logic [4:0]  tx_len;
    logic        tx_start;
    logic        tx_busy;
    logic        send;
    logic        controller_init;
    logic        rx_id_ready;
    logic        rx_button_ready;
    logic        link_up;
    logic        busy;
    logic [7:0]  timeout_count;
    logic [15:0] poll_count;

    modport master (
        input  enable, init_req, tx_busy, rx_id_ready, rx_button_ready,
        output tx_cmd, tx_len, tx_start, send, controller_init, link_up, busy,
               timeout_count, poll_count
    );

    modport slave (
        output enable, init_req, tx_busy, rx_id_ready, rx_button_ready,
        input  tx_cmd, tx_len, tx_start, send, controller_init, link_up, busy,
               timeout_count, poll_count
    );
endinterface

// File: rtl/gc_timeout_ctr.sv
// Loadable down-counter; expired holds once an armed count reaches zero until cleared/reloaded.
module gc_timeout_ctr #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [Width-1:0] load_i,
    output logic             expired_o
);
    logic [Width-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (clear_i) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (start_i) begin
            cnt_d   = load_i;
            armed_d = 1'b1;
        end else if (armed_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign expired_o = armed_q && (cnt_q == '0);
endmodule

// File: rtl/gc_poll_sequencer.sv
// GameCube link sequencer: identify after init, periodic polls, response timeout with retries.
module gc_poll_sequencer
    import gc_pkg::*;
#(
    parameter int unsigned POLL_PERIOD  = 100000,
    parameter int unsigned RESP_TIMEOUT = 40000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [7:0]  ID_CMD       = GC_ID_CMD,
    parameter logic [23:0] POLL_CMD     = GC_POLL_CMD
) (
    input logic                 clk,
    input logic                 rst,
    gc_poll_sequencer_if.master bus
);
    localparam int unsigned PerW   = $clog2(POLL_PERIOD);
    localparam int unsigned RspW   = $clog2(RESP_TIMEOUT + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

    gc_seq_state_t     state_q, state_d;
    logic              started_q, started_d, seen_busy_q, seen_busy_d;
    logic              tx_start_q, tx_start_d, send_q, send_d, link_up_q, link_up_d;
    logic [23:0]       tx_cmd_q, tx_cmd_d;
    logic [4:0]        tx_len_q, tx_len_d;
    logic [RetryW-1:0] retry_q, retry_d, retry_inc;
    logic [7:0]        tmo_cnt_q, tmo_cnt_d;
    logic [15:0]       poll_cnt_q, poll_cnt_d;
    logic              per_start, per_clear, per_expired;
    logic              rsp_start, rsp_clear, rsp_expired;
    logic              in_tx, tx_done;

    // Loaded at the tx_start decision so the next poll tx_start lands exactly POLL_PERIOD later.
    gc_timeout_ctr #(.Width(PerW)) u_period_ctr (
        .clk       (clk),
        .rst       (rst),
        .start_i   (per_start),
        .clear_i   (per_clear),
        .load_i    (PerW'(POLL_PERIOD - 2)),
        .expired_o (per_expired)
    );

    gc_timeout_ctr #(.Width(RspW)) u_resp_ctr (
        .clk       (clk),
        .rst       (rst),
        .start_i   (rsp_start),
        .clear_i   (rsp_clear),
        .load_i    (RspW'(RESP_TIMEOUT)),
        .expired_o (rsp_expired)
    );

    assign in_tx     = (state_q == StIdTx) || (state_q == StPollTx);
    assign retry_inc = retry_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        started_d   = started_q;
        seen_busy_d = seen_busy_q;
        tx_start_d  = 1'b0;
        send_d      = send_q;
        tx_cmd_d    = tx_cmd_q;
        tx_len_d    = tx_len_q;
        link_up_d   = link_up_q;
        retry_d     = retry_q;
        tmo_cnt_d   = tmo_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        per_start   = 1'b0;
        per_clear   = 1'b0;
        rsp_start   = 1'b0;
        rsp_clear   = 1'b0;
        tx_done     = 1'b0;

        if (in_tx) begin
            if (!started_q) begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    started_d  = 1'b1;
                    send_d     = 1'b1;
                    if (state_q == StPollTx) begin
                        tx_cmd_d  = POLL_CMD;
                        tx_len_d  = 5'd24;
                        per_start = 1'b1;
                    end else begin
                        tx_cmd_d = {ID_CMD, 16'h0000};
                        tx_len_d = 5'd8;
                    end
                end
            end else begin
                seen_busy_d = seen_busy_q | bus.tx_busy;
                tx_done     = seen_busy_q & ~bus.tx_busy;
            end
        end

        unique case (state_q)
            StIdle: begin
                per_clear = 1'b1;
                if (bus.enable && bus.init_req) begin
                    retry_d = '0;
                    state_d = StIdTx;
                end else if (bus.enable && link_up_q) begin
                    state_d = StPollTx;
                end
            end
            StIdTx, StPollTx: begin
                if (tx_done) begin
                    send_d    = 1'b0;
                    rsp_start = 1'b1;
                    state_d   = (state_q == StIdTx) ? StIdWait : StPollWait;
                end
            end
            StIdWait: begin
                // Ready wins over a same-cycle timeout.
                if (bus.rx_id_ready) begin
                    link_up_d = 1'b1;
                    retry_d   = '0;
                    rsp_clear = 1'b1;
                    state_d   = StPollTx;
                end else if (rsp_expired) begin
                    rsp_clear = 1'b1;
                    if (retry_inc >= RetryW'(MAX_RETRY)) begin
                        link_up_d = 1'b0;
                        retry_d   = '0;
                        state_d   = StIdle;
                    end else begin
                        retry_d = retry_inc;
                        state_d = StIdTx;
                    end
                end
            end
            StPollWait: begin
                if (bus.rx_button_ready) begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                    retry_d    = '0;
                    rsp_clear  = 1'b1;
                    state_d    = StPollGap;
                end else if (rsp_expired) begin
                    rsp_clear = 1'b1;
                    if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (retry_inc >= RetryW'(MAX_RETRY)) begin
                        link_up_d = 1'b0;
                        retry_d   = '0;
                        state_d   = StIdle;
                    end else begin
                        retry_d = retry_inc;
                        state_d = StPollGap;
                    end
                end
            end
            StPollGap: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (bus.init_req) begin
                    per_clear = 1'b1;
                    retry_d   = '0;
                    state_d   = StIdTx;
                end else if (per_expired) begin
                    state_d = StPollTx;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            started_d   = 1'b0;
            seen_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            started_q   <= 1'b0;
            seen_busy_q <= 1'b0;
            tx_start_q  <= 1'b0;
            send_q      <= 1'b0;
            tx_cmd_q    <= '0;
            tx_len_q    <= '0;
            link_up_q   <= 1'b0;
            retry_q     <= '0;
            tmo_cnt_q   <= '0;
            poll_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            seen_busy_q <= seen_busy_d;
            tx_start_q  <= tx_start_d;
            send_q      <= send_d;
            tx_cmd_q    <= tx_cmd_d;
            tx_len_q    <= tx_len_d;
            link_up_q   <= link_up_d;
            retry_q     <= retry_d;
            tmo_cnt_q   <= tmo_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
        end
    end

    assign bus.tx_cmd          = tx_cmd_q;
    assign bus.tx_len          = tx_len_q;
    assign bus.tx_start        = tx_start_q;
    assign bus.send            = send_q;
    assign bus.controller_init = (state_q == StIdTx) || (state_q == StIdWait);
    assign bus.link_up         = link_up_q;
    assign bus.busy            = (state_q != StIdle);
    assign bus.timeout_count   = tmo_cnt_q;
    assign bus.poll_count      = poll_cnt_q;
endmodule

// File: doc/gc_poll_sequencer.md
# gc_poll_sequencer

Sequences all traffic on the GameCube controller single-wire link. It owns the bit transmitter and the `gc_receive` capture block. It issues the identify command after an init request, then issues the 24-bit poll command at a fixed period, enforces a response timeout with bounded retries, and reports link status to the APB register block.

## Interface
Parameters:
- `POLL_PERIOD`, 100000: cycles from one poll `tx_start` to the next (1 ms at 100 MHz).
- `RESP_TIMEOUT`, 40000: cycles allowed after `tx_busy` falls for the response-ready pulse.
- `MAX_RETRY`, 3: consecutive timeouts tolerated before `link_up` drops.
- `ID_CMD`, 8'h00: identify command byte.
- `POLL_CMD`, 24'h400300: poll command.

Ports:
- `clk` in 1: single clock. Everything is posedge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level. Low parks the FSM in IDLE after any in-flight transaction completes.
- `init_req` in 1: one-cycle pulse from the APB block; requests the identify sequence.
- `tx_cmd` out 24: command for the transmitter, left-justified; bit 23 is sent first.
- `tx_len` out 5: number of command bits (8 or 24).
- `tx_start` out 1: one-cycle pulse; transmitter latches `tx_cmd`/`tx_len`.
- `tx_busy` in 1: high while the transmitter is driving the line.
- `send` out 1: to the receiver; masks edge detection while the host drives.
- `controller_init` out 1: to the receiver; selects 24-bit ID capture versus 64-bit button capture.
- `rx_id_ready` in 1: pulse from the receiver when the 24-bit ID is captured.
- `rx_button_ready` in 1: pulse from the receiver when the 64-bit button word is captured.
- `link_up` out 1: registered; a response arrived and there have been fewer than `MAX_RETRY` consecutive timeouts.
- `busy` out 1: FSM is not in IDLE.
- `timeout_count` out 8: saturating count of timeouts since reset.
- `poll_count` out 16: count of good button responses since reset; wraps.

## Operation
- States: IDLE, ID_TX, ID_WAIT, POLL_TX, POLL_WAIT, POLL_GAP.
- **IDLE**
  - `init_req` && `enable` → ID_TX.
  - Otherwise, if `link_up` && `enable` → POLL_TX.
- **ID_TX**
  - Drive `tx_cmd={ID_CMD,16'h0}`, `tx_len=8`, `controller_init=1`.
  - Pulse `tx_start` on the first cycle in which `tx_busy=0`. Then wait for `tx_busy` to fall, then go to ID_WAIT.
- **ID_WAIT**
  - `rx_id_ready` → set `link_up`, clear retry count, go to POLL_TX.
  - Timeout → increment retry count. Retry ID_TX while retries < `MAX_RETRY`; otherwise go to IDLE with `link_up=0`.
- **POLL_TX**
  - `tx_cmd=POLL_CMD`, `tx_len=24`, `controller_init=0`, otherwise same handshake as ID_TX.
  - The period counter restarts at `tx_start`.
- **POLL_WAIT**
  - `rx_button_ready` → `poll_count`++, clear retry count, go to POLL_GAP.
  - Timeout → `timeout_count`++ (saturates at 255), retry count++.
    - Retry count reaching `MAX_RETRY` → `link_up=0`, go to IDLE.
    - Otherwise go to POLL_GAP.
- **POLL_GAP**
  - The period counter reaching `POLL_PERIOD-1` → POLL_TX.
  - `enable=0` → IDLE.
  - `init_req` → ID_TX; this has priority over the period expiring.
- **`send`**: high from the `tx_start` cycle until the cycle after `tx_busy` falls.
- **`controller_init`**: held from ID_TX entry until ID_WAIT exit, so that a late ID response is still captured in 24-bit mode.
- **Ignored inputs**: an `init_req` arriving during ID_TX/ID_WAIT is ignored. `rx_*_ready` pulses outside the matching WAIT state are ignored.
- **Arithmetic widths**: timeout counter is `$clog2(RESP_TIMEOUT+1)` bits; period counter is `$clog2(POLL_PERIOD)` bits; both are unsigned and reset to 0 on every state entry that uses them.

## Timing
- **Reset values**: all outputs 0; `tx_cmd` 0, `tx_len` 0, counters 0; state IDLE. `rst` aborts any transaction immediately, and `send` drops asynchronously.
- **Start latency**: `tx_start` occurs 1 cycle after entering a TX state when `tx_busy=0`.
- **Timeout**: fires on the cycle the timeout counter equals `RESP_TIMEOUT`, counted from the first cycle after `tx_busy` falls.
- **Simultaneous events**:
  - A ready pulse in the same cycle as the timeout counts as success.
  - `enable` falling during TX/WAIT takes effect on the next POLL_GAP/IDLE decision.
- `link_up` and the status counters update on the cycle after the triggering event.

## Structure
- `gc_pkg`: state enum `gc_seq_state_t`, `GC_ID_CMD`, `GC_POLL_CMD`, `GC_ID_BITS=24`, `GC_BUTTON_BITS=64`. This package is shared with the transmitter and receiver.
- Sub-module `gc_timeout_ctr`: loadable down-counter with start/clear/expired, instantiated twice (period and response).

## Test plan
- **Init success**: reset, `enable=1`, `init_req` pulse.
  - `tx_start` with `tx_cmd=24'h000000`, `tx_len=8`, `controller_init=1`.
  - Model returns the ID → `link_up=1`, then a poll `tx_start` with `tx_cmd=24'h400300`, `tx_len=24`.
- **Periodic poll**: with `POLL_PERIOD=200` and the model always responding, successive `tx_start` pulses are exactly 200 cycles apart; `poll_count` reaches 5 after 5 responses.
- **Timeout and retry**: with `RESP_TIMEOUT=50` and `MAX_RETRY=3`, the model goes silent.
  - Three polls, `timeout_count=3`, `link_up` falls the cycle after the third timeout, FSM returns to IDLE.
- **Late ID**: the ID response arrives on the same cycle as the timeout → treated as success; `controller_init` is still 1 at capture.
- **`send` masking**: `send` is high from `tx_start` through `tx_busy` falling +1 cycle. Injecting a `rx_button_ready` pulse during POLL_TX does not change `poll_count`.
- **Reset mid-poll**: assert `rst` during POLL_WAIT → `send`, `link_up`, `busy` are 0 immediately. After release, no `tx_start` occurs without a new `init_req`.
